// File: rtl/serial_sub_pkg.sv
// serial_sub shared definitions: FSM encoding and default operand width.
// Imported by the bit-serial subtractor datapath and its full-subtractor cell.
package serial_sub_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One full-subtractor step packed as {borrow_out, diff}.
  function automatic logic [1:0] fsub_bit(
    input logic a,
    input logic b,
    input logic br
  );
    logic d;
    logic bo;
    d  = a ^ b ^ br;
    bo = (~a & b) | (~(a ^ b) & br);
    return {bo, d};
  endfunction

endpackage

// File: rtl/serial_sub_f_sub.sv
// f_sub: combinational one-bit full subtractor (a - b - borrowIN).
// The serial datapath instances exactly one of these.
module f_sub
  import serial_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic borrowIN,
  output logic diff,
  output logic borrowOUT
);

  logic [1:0] w_res;

  assign w_res     = fsub_bit(a, b, borrowIN);
  assign diff      = w_res[0];
  assign borrowOUT = w_res[1];

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial ripple subtractor, LSB first, one bit per clock.
// start/busy/done handshake; diff and borrowOUT hold until the next DONE.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrowIN,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowOUT
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_bout;
  logic [CW-1:0]    r_cnt;

  logic             w_d;
  logic             w_br_nxt;
  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  f_sub u_fsub (
    .a         (r_a[0]),
    .b         (r_b[0]),
    .borrowIN  (r_br),
    .diff      (w_d),
    .borrowOUT (w_br_nxt)
  );

  // Newest bit enters at the MSB; after WIDTH steps this is the full result.
  assign w_res_nxt = {w_d, r_res};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_load) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= borrowIN;
      r_cnt <= '0;
    end else if (w_step) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_br  <= w_br_nxt;
      r_res <= w_res_nxt[WIDTH-1:1];
      r_cnt <= r_cnt + CW'(1);
      // Publish only on entry to DONE so diff never shows partial bits.
      if (w_last) begin
        r_diff <= w_res_nxt;
        r_bout <= w_br_nxt;
      end
    end
  end

  assign busy      = (r_state == SHIFT);
  assign done      = (r_state == DONE);
  assign diff      = r_diff;
  assign borrowOUT = r_bout;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: serial_sub at WIDTH 8, 2 and 32 against an
// arithmetic model {borrowOUT,diff} = a - b - borrowIN with cycle timing.
module tb_serial_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ta  [3];
  logic [31:0] tbv [3];
  logic        tst [3];
  logic        tbi [3];
  logic [31:0] odiff [3];
  logic        obusy [3];
  logic        odone [3];
  logic        obout [3];
  int          ndone [3] = '{default: 0};

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input int          w,
    input logic [32:0] act,
    input logic [32:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s w=%0d got %h want %h t=%0t",
               nm, w, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int W = (gi == 0) ? 8 : (gi == 1) ? 2 : 32;

    logic         w_busy;
    logic         w_done;
    logic         w_bout;
    logic [W-1:0] w_diff;

    serial_sub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (tst[gi]),
      .a         (ta[gi][W-1:0]),
      .b         (tbv[gi][W-1:0]),
      .borrowIN  (tbi[gi]),
      .busy      (w_busy),
      .done      (w_done),
      .diff      (w_diff),
      .borrowOUT (w_bout)
    );

    assign odiff[gi] = 32'(w_diff);
    assign obusy[gi] = w_busy;
    assign odone[gi] = w_done;
    assign obout[gi] = w_bout;

    int         m_left = 0;
    logic       m_done = 1'b0;
    logic [W:0] m_pend = '0;
    logic [W:0] m_res  = '0;

    always begin
      @(posedge clk);
      if (!rst_n) begin
        m_left = 0;
        m_done = 1'b0;
        m_res  = '0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_res  = m_pend;
          ndone[gi]++;
        end
      end else begin
        m_done = 1'b0;
        if (tst[gi]) begin
          m_left = W;
          m_pend = {1'b0, ta[gi][W-1:0]}
                 - {1'b0, tbv[gi][W-1:0]}
                 - (W+1)'(tbi[gi]);
        end
      end
      #1;
      chk("busy", W, 33'(w_busy), 33'(m_left > 0));
      chk("done", W, 33'(w_done), 33'(m_done));
      chk("diff", W, 33'(w_diff), 33'(m_res[W-1:0]));
      chk("bout", W, 33'(w_bout), 33'(m_res[W]));
    end
  end

  logic fa, fb, fbi, fd, fbo;

  f_sub u_fs (
    .a         (fa),
    .b         (fb),
    .borrowIN  (fbi),
    .diff      (fd),
    .borrowOUT (fbo)
  );

  task automatic issue(
    input int          i,
    input logic [31:0] av,
    input logic [31:0] bv,
    input logic        bi
  );
    ta[i]  = av;
    tbv[i] = bv;
    tbi[i] = bi;
    tst[i] = 1'b1;
    @(negedge clk);
    tst[i] = 1'b0;
  endtask

  task automatic wait_done(
    input  int i,
    output int lat,
    output int nb
  );
    lat = 1;
    nb  = 0;
    while (!odone[i] && lat < 200) begin
      if (obusy[i]) nb++;
      @(negedge clk);
      lat++;
    end
    if (!odone[i]) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout inst=%0d got none want pulse", i);
    end
  endtask

  task automatic run8(
    input logic [7:0] av,
    input logic [7:0] bv,
    input logic       bi,
    input logic [7:0] ed,
    input logic       eb
  );
    int lat, nb;
    issue(0, 32'(av), 32'(bv), bi);
    wait_done(0, lat, nb);
    chk("lit_diff", 8, 33'(odiff[0]), 33'(ed));
    chk("lit_bout", 8, 33'(obout[0]), 33'(eb));
    chk("lat", 8, 33'(lat), 33'd9);
    chk("busy_cyc", 8, 33'(nb), 33'd8);
  endtask

  initial begin
    int lat, nb, r;
    int base [3];
    int c;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ta[i]  = '0;
      tbv[i] = '0;
      tbi[i] = 1'b0;
      tst[i] = 1'b0;
    end

    for (int k = 0; k < 8; k++) begin
      fa  = k[2];
      fb  = k[1];
      fbi = k[0];
      r   = int'(fa) - int'(fb) - int'(fbi);
      #1;
      chk("fsub_d", 1, 33'(fd), 33'(r & 1));
      chk("fsub_b", 1, 33'(fbo), 33'(r < 0));
    end

    repeat (2) @(negedge clk);
    chk("rst_busy", 8, 33'(obusy[0]), 33'd0);
    chk("rst_done", 8, 33'(odone[0]), 33'd0);
    chk("rst_diff", 8, 33'(odiff[0]), 33'd0);
    chk("rst_bout", 8, 33'(obout[0]), 33'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    run8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);
    run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b0);

    issue(0, 32'h5A, 32'h3C, 1'b0);
    repeat (2) @(negedge clk);
    issue(0, 32'hFF, 32'h00, 1'b0);
    wait_done(0, lat, nb);
    chk("ign_diff", 8, 33'(odiff[0]), 33'h1E);
    chk("ign_bout", 8, 33'(obout[0]), 33'd0);
    issue(0, 32'h33, 32'h11, 1'b0);
    wait_done(0, lat, nb);
    chk("b2b_diff", 8, 33'(odiff[0]), 33'h22);
    chk("b2b_lat", 8, 33'(lat), 33'd9);

    issue(0, 32'h5A, 32'h3C, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 8, 33'(obusy[0]), 33'd0);
    chk("arst_done", 8, 33'(odone[0]), 33'd0);
    chk("arst_diff", 8, 33'(odiff[0]), 33'd0);
    chk("arst_bout", 8, 33'(obout[0]), 33'd0);
    repeat (3) begin
      @(negedge clk);
      chk("arst_nodone", 8, 33'(odone[0]), 33'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run8(8'h5A, 8'h3C, 1'b1, 8'h1D, 1'b0);

    for (int i = 0; i < 3; i++) base[i] = ndone[i];
    c = 0;
    while (c < 45000 &&
           !(ndone[0] - base[0] >= 1000 &&
             ndone[1] - base[1] >= 1000 &&
             ndone[2] - base[2] >= 1000)) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        ta[i]  = $urandom;
        tbv[i] = $urandom;
        tbi[i] = 1'($urandom_range(0, 1));
        tst[i] = ($urandom_range(0, 3) != 0);
      end
      c++;
    end
    for (int i = 0; i < 3; i++) tst[i] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (ndone[i] - base[i] < 1000) begin
        n_vec++;
        n_err++;
        $display("FAIL rand_count inst=%0d got %0d want 1000",
                 i, ndone[i] - base[i]);
      end
    end
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
